// File: rtl/pipe_credit_rx.sv
// pipe_credit_rx: sink for a no-backpressure pipeline.
// FWFT FIFO with one credit pulse returned per popped word.
module pipe_credit_rx #(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 16,
  parameter  int CREDIT_LAT = 1,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             credit_out,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic [CREDIT_LAT-1:0] r_credit;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_drop;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL);
  assign w_push   = in_valid & ~rst;
  assign w_pop    = ~w_empty & out_ready;
  // Full with a pop frees the head slot this edge, so the
  // write lands on the entry being read out.
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;

  assign out_valid  = ~w_empty;
  assign out_data   = r_mem[r_rptr];
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign credit_out = r_credit[CREDIT_LAT-1];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // Pointers wrap modulo DEPTH; occupancy tracks accept/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag for a word lost while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Credit delay line; each pop yields its own pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= '0;
    end else begin
      r_credit[0] <= w_pop;
      for (int i = 1; i < CREDIT_LAT; i++) begin
        r_credit[i] <= r_credit[i-1];
      end
    end
  end

  a_count_max: assert property (
    @(posedge clk) disable iff (rst)
    r_count <= FULL
  );

  a_head_stable: assert property (
    @(posedge clk) disable iff (rst)
    (out_valid & ~out_ready) |=> $stable(out_data)
  );

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (rst)
    w_empty |-> ~w_pop
  );

endmodule

// File: tb/tb_pipe_credit_rx.sv
// tb_pipe_credit_rx: directed and random checks
// for the credit-returning pipeline sink FIFO.
module tb_pipe_credit_rx;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        credit_out;
  logic [4:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  pipe_credit_rx #(
    .WIDTH(32),
    .DEPTH(16),
    .CREDIT_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .credit_out(credit_out),
    .count(count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (count !== 5'd0) begin errors++;
      $display("FAIL reset_count: got %0d want 0", count); end
    checks++;
    if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (overflow !== 1'b0) begin errors++;
      $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++;
    if (credit_out !== 1'b0) begin errors++;
      $display("FAIL reset_credit: got %b want 0", credit_out); end
  endtask

  task automatic test_single_word;
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++;
      $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++;
    if (out_data !== 32'hA5A5_0001) begin errors++;
      $display("FAIL single_data: got %h want a5a50001", out_data); end
    checks++;
    if (credit_out !== 1'b0) begin errors++;
      $display("FAIL single_credit_early: got %b want 0", credit_out); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin errors++;
      $display("FAIL single_popped: got v=%b c=%0d want v=0 c=0",
               out_valid, count); end
    checks++;
    if (credit_out !== 1'b1) begin errors++;
      $display("FAIL single_credit: got %b want 1", credit_out); end
    tick();
    checks++;
    if (credit_out !== 1'b0) begin errors++;
      $display("FAIL single_credit_width: got %b want 0", credit_out); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_drain;
    int k;
    int cr;
    fill(32'h0);
    checks++;
    if (count !== 5'd16) begin errors++;
      $display("FAIL fill_count: got %0d want 16", count); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0) begin errors++;
      $display("FAIL fill_head: got v=%b d=%h want v=1 d=0",
               out_valid, out_data); end
    k = 0; cr = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        checks++;
        if (out_data !== 32'(k)) begin errors++;
          $display("FAIL drain_data: got %h want %h", out_data, k); end
        k++;
      end
      tick();
      if (credit_out) cr++;
    end
    out_ready = 1'b0;
    checks++;
    if (k !== 16) begin errors++;
      $display("FAIL drain_words: got %0d want 16", k); end
    checks++;
    if (cr !== 16) begin errors++;
      $display("FAIL drain_credits: got %0d want 16", cr); end
    checks++;
    if (count !== 5'd0) begin errors++;
      $display("FAIL drain_count: got %0d want 0", count); end
  endtask

  task automatic test_full_push_pop;
    int k;
    logic [31:0] want;
    fill(32'h0);
    in_valid = 1'b1; in_data = 32'h100; out_ready = 1'b1;
    checks++;
    if (out_data !== 32'h0) begin errors++;
      $display("FAIL fpp_head: got %h want 0", out_data); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0) begin errors++;
      $display("FAIL fpp_state: got c=%0d o=%b want c=16 o=0",
               count, overflow); end
    k = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        want = (k < 15) ? 32'(k + 1) : 32'h100;
        checks++;
        if (out_data !== want) begin errors++;
          $display("FAIL fpp_data: got %h want %h", out_data, want); end
        k++;
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (k !== 16 || count !== 5'd0) begin errors++;
      $display("FAIL fpp_words: got k=%0d c=%0d want k=16 c=0",
               k, count); end
  endtask

  task automatic test_overflow;
    int k;
    fill(32'h200);
    in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin errors++;
      $display("FAIL ovf_set: got o=%b c=%0d want o=1 c=16",
               overflow, count); end
    checks++;
    if (out_data !== 32'h200) begin errors++;
      $display("FAIL ovf_head: got %h want 200", out_data); end
    tick();
    checks++;
    if (overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_sticky: got %b want 1", overflow); end
    k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        checks++;
        if (out_data !== 32'h200 + 32'(k)) begin errors++;
          $display("FAIL ovf_data: got %h want %h",
                   out_data, 32'h200 + 32'(k)); end
        k++;
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (k !== 16 || overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_drain: got k=%0d o=%b want k=16 o=1",
               k, overflow); end
  endtask

  task automatic test_reset_mid_traffic;
    fill(32'h300);
    rst = 1'b1; in_valid = 1'b1;
    in_data = 32'h777; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL rmid_state: got c=%0d v=%b want c=0 v=0",
               count, out_valid); end
    checks++;
    if (overflow !== 1'b0) begin errors++;
      $display("FAIL rmid_ovf: got %b want 0", overflow); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (credit_out !== 1'b0 || out_valid !== 1'b0) begin errors++;
        $display("FAIL rmid_quiet: got cr=%b v=%b want 0 0",
                 credit_out, out_valid); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    int credits;
    int sent;
    int popped;
    int crtot;
    int ovf_seen;
    logic        pv [3];
    logic [31:0] pd [3];
    logic [31:0] q [$];
    logic [31:0] w;
    logic        snd;
    credits = 16; sent = 0; popped = 0;
    crtot = 0; ovf_seen = 0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; pd[i] = '0;
    end
    for (int c = 0; c < 10060; c++) begin
      if (credit_out) begin credits++; crtot++; end
      if (overflow) ovf_seen = 1;
      snd = (c < 10000) && (credits > 0) &&
            ($urandom_range(0, 99) < 60);
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = snd;   pd[0] = $urandom;
      if (snd) begin
        credits--; sent++;
        q.push_back(pd[0]);
      end
      in_valid  = pv[2];
      in_data   = pd[2];
      out_ready = (c >= 10000) || ($urandom_range(0, 99) < 50);
      if (out_valid && out_ready) begin
        popped++;
        checks++;
        if (q.size() == 0) begin errors++;
          $display("FAIL rnd_extra: got %h want none", out_data);
        end else begin
          w = q.pop_front();
          if (out_data !== w) begin errors++;
            $display("FAIL rnd_data: got %h want %h", out_data, w); end
        end
      end
      tick();
    end
    if (credit_out) begin credits++; crtot++; end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (ovf_seen !== 0 || overflow !== 1'b0) begin errors++;
      $display("FAIL rnd_ovf: got %b want 0", overflow); end
    checks++;
    if (q.size() !== 0 || popped !== sent) begin errors++;
      $display("FAIL rnd_count: got popped=%0d want %0d", popped, sent); end
    checks++;
    if (crtot !== popped) begin errors++;
      $display("FAIL rnd_credits: got %0d want %0d", crtot, popped); end
    checks++;
    if (credits !== 16 || count !== 5'd0) begin errors++;
      $display("FAIL rnd_final: got cr=%0d c=%0d want 16 0",
               credits, count); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_drain();
    test_full_push_pop();
    test_overflow();
    test_reset_mid_traffic();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
